integration_scheduler: RTL and testbench



---
 rtl/integration_scheduler.sv | 161 ++++++++++++++++
 tb/tb_integration_scheduler.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/integration_scheduler.sv
// Integration period sequencer: a free-running period counter issues the
// integration strobe and snapshot command; each snapshot frame is read from
// snapshot memory and serialized as bytes onto a valid/ready UART interface.
module integration_scheduler #(
  parameter int NUM_INPUTS      = 12,
  parameter int NUM_CORRELATORS = NUM_INPUTS * (NUM_INPUTS - 1) / 2,
  parameter int NUM_WORDS       = NUM_INPUTS + NUM_CORRELATORS,
  parameter int RESOLUTION      = 16,
  parameter int PERIOD_WIDTH    = 32,
  parameter int ADDR_WIDTH      = 8
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    enable,
  input  logic [PERIOD_WIDTH-1:0] period,
  output logic                    integration_clk_pulse,
  output logic                    snapshot,
  output logic [ADDR_WIDTH-1:0]   rd_addr,
  input  logic [RESOLUTION-1:0]   rd_data,
  output logic [7:0]              tx_data,
  output logic                    tx_valid,
  input  logic                    tx_ready,
  output logic                    busy,
  output logic                    overrun
);

  localparam int BYTES = RESOLUTION / 8;
  localparam int BCW   = $clog2(BYTES) + 1;
  localparam logic [ADDR_WIDTH-1:0] LAST_WORD = ADDR_WIDTH'(NUM_WORDS - 1);
  localparam logic [BCW-1:0]        LAST_BYTE = BCW'(BYTES - 1);

  // Handshake: a byte moves on any cycle with tx_valid && tx_ready; while
  // tx_valid is high and tx_ready low, tx_data and the FSM state are frozen.
  typedef enum logic [2:0] {
    IDLE, HDR, CNT, RADDR, RWAIT, SEND, SUM
  } state_t;

  state_t                  state, state_next;
  logic [PERIOD_WIDTH-1:0] count, p_reg, p_eff;
  logic [ADDR_WIDTH-1:0]   word_idx;
  logic [BCW-1:0]          byte_cnt;
  logic [RESOLUTION-1:0]   shreg;
  logic [7:0]              checksum, frame_cnt;
  logic                    hs;

  assign p_eff = (period < PERIOD_WIDTH'(2)) ? PERIOD_WIDTH'(2) : period;

  // Period counter runs independently of readout so boundaries never slip.
  always_ff @(posedge clk) begin
    if (reset) begin
      count                 <= '0;
      p_reg                 <= '0;
      integration_clk_pulse <= 1'b0;
    end else begin
      integration_clk_pulse <= 1'b0;
      if (!enable) begin
        count <= '0;
      end else if (count == '0) begin
        p_reg <= p_eff;
        count <= PERIOD_WIDTH'(1);
      end else if (count == p_reg - PERIOD_WIDTH'(1)) begin
        integration_clk_pulse <= 1'b1;
        count                 <= '0;
      end else begin
        count <= count + PERIOD_WIDTH'(1);
      end
    end
  end

  assign busy     = (state != IDLE);
  assign snapshot = integration_clk_pulse && !busy;
  assign tx_valid = (state == HDR) || (state == CNT) || (state == SEND) || (state == SUM);
  assign hs       = tx_valid && tx_ready;
  assign rd_addr  = word_idx;

  always_ff @(posedge clk) begin
    if (reset) begin
      overrun <= 1'b0;
    end else if (integration_clk_pulse && busy) begin
      overrun <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    tx_data    = 8'h00;
    case (state)
      IDLE:  if (snapshot) state_next = HDR;
      HDR: begin
        tx_data = 8'hA5;
        if (hs) state_next = CNT;
      end
      CNT: begin
        tx_data = frame_cnt;
        if (hs) state_next = RADDR;
      end
      RADDR: state_next = RWAIT;
      RWAIT: state_next = SEND;
      SEND: begin
        tx_data = shreg[RESOLUTION-1 -: 8];
        if (hs && byte_cnt == LAST_BYTE) begin
          state_next = (word_idx == LAST_WORD) ? SUM : RADDR;
        end
      end
      SUM: begin
        tx_data = checksum;
        if (hs) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      word_idx  <= '0;
      byte_cnt  <= '0;
      shreg     <= '0;
      checksum  <= '0;
      frame_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (snapshot) begin
            checksum <= '0;
            word_idx <= '0;
          end
        end
        CNT: begin
          if (hs) checksum <= checksum ^ frame_cnt;
        end
        RWAIT: begin
          shreg    <= rd_data;
          byte_cnt <= '0;
        end
        SEND: begin
          if (hs) begin
            checksum <= checksum ^ shreg[RESOLUTION-1 -: 8];
            shreg    <= shreg << 8;
            byte_cnt <= byte_cnt + BCW'(1);
            if (byte_cnt == LAST_BYTE && word_idx != LAST_WORD) begin
              word_idx <= word_idx + ADDR_WIDTH'(1);
            end
          end
        end
        SUM: begin
          if (hs) frame_cnt <= frame_cnt + 8'd1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_integration_scheduler.sv
// Randomized bench for integration_scheduler: a cycle-level reference model
// predicts strobes, busy/overrun and the full byte stream of every frame.
module tb_integration_scheduler;

  localparam int NI    = 12;
  localparam int NW    = NI + NI * (NI - 1) / 2;
  localparam int RES   = 16;
  localparam int BYTES = RES / 8;
  localparam int FRAME_LEN = 3 + NW * (2 + BYTES);

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        enable = 1'b0;
  logic [31:0] period = 32'd10;
  logic        integration_clk_pulse, snapshot, busy, overrun;
  logic [7:0]  rd_addr;
  logic [RES-1:0] rd_data = '0;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready = 1'b1;

  integration_scheduler dut (
    .clk(clk), .reset(reset), .enable(enable), .period(period),
    .integration_clk_pulse(integration_clk_pulse), .snapshot(snapshot),
    .rd_addr(rd_addr), .rd_data(rd_data), .tx_data(tx_data),
    .tx_valid(tx_valid), .tx_ready(tx_ready), .busy(busy), .overrun(overrun)
  );

  // clock/reset block
  always #5 clk = ~clk;

  // snapshot memory with one-cycle read latency
  logic [RES-1:0] mem [0:255];
  int mem_mode = 0;
  always @(posedge clk) rd_data <= mem[rd_addr];

  // scoreboard state
  logic [7:0] exp_q[$];
  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // inputs as seen by the DUT at the last rising edge
  logic        en_s = 1'b0, rst_s = 1'b1, seen_edge = 1'b0;
  logic [31:0] per_s = '0;
  always @(posedge clk) begin
    en_s = enable; rst_s = reset; per_s = period; seen_edge = 1'b1;
  end

  // reference model
  int   ticks = 0, p_m = 2, len = 0;
  logic busy_m = 0, overrun_m = 0, all_ready = 1, prev_stall = 0;
  logic [7:0] fc_m = 0, prev_data = 0;

  task automatic push_frame();
    logic [7:0] sum, b;
    for (int n = 0; n < NW; n++)
      mem[n] = (mem_mode == 0) ? RES'(16'h0100 + n) : RES'($urandom);
    exp_q.push_back(8'hA5);
    exp_q.push_back(fc_m);
    sum = fc_m;
    for (int n = 0; n < NW; n++)
      for (int k = BYTES - 1; k >= 0; k--) begin
        b = 8'((mem[n] >> (8 * k)) & 'hFF);
        exp_q.push_back(b);
        sum = sum ^ b;
      end
    exp_q.push_back(sum);
    fc_m = fc_m + 8'd1;
  endtask

  // monitor: compares DUT outputs against the model on every falling edge
  always @(negedge clk) begin
    logic exp_pulse, busy_nx;
    logic [7:0] e;
    if (seen_edge) begin
      if (rst_s) begin
        chk("rst_pulse", {31'd0, integration_clk_pulse}, 0);
        chk("rst_snapshot", {31'd0, snapshot}, 0);
        chk("rst_rd_addr", {24'd0, rd_addr}, 0);
        chk("rst_tx_data", {24'd0, tx_data}, 0);
        chk("rst_tx_valid", {31'd0, tx_valid}, 0);
        chk("rst_busy", {31'd0, busy}, 0);
        chk("rst_overrun", {31'd0, overrun}, 0);
        ticks = 0; fc_m = 0; busy_m = 0; overrun_m = 0;
        exp_q.delete(); prev_stall = 0; len = 0; all_ready = 1;
      end else begin
        exp_pulse = 1'b0;
        if (en_s) begin
          ticks++;
          if (ticks == 1) p_m = (per_s < 2) ? 2 : int'(per_s);
          if (ticks == p_m) begin
            exp_pulse = 1'b1;
            ticks = 0;
          end
        end else begin
          ticks = 0;
        end
        chk("pulse", {31'd0, integration_clk_pulse}, {31'd0, exp_pulse});
        chk("busy", {31'd0, busy}, {31'd0, busy_m});
        chk("overrun", {31'd0, overrun}, {31'd0, overrun_m});
        chk("snapshot", {31'd0, snapshot}, {31'd0, exp_pulse && !busy_m});
        if (prev_stall) begin
          chk("stall_valid", {31'd0, tx_valid}, 1);
          chk("stall_data", {24'd0, tx_data}, {24'd0, prev_data});
        end
        prev_stall = tx_valid && !tx_ready;
        prev_data  = tx_data;
        busy_nx = busy_m;
        if (busy_m) begin
          len++;
          if (!tx_ready) all_ready = 0;
        end
        if (tx_valid && tx_ready) begin
          if (exp_q.size() == 0) begin
            chk("unexpected_byte", {24'd0, tx_data}, 32'hFFFF_FFFF);
          end else begin
            e = exp_q.pop_front();
            chk("tx_byte", {24'd0, tx_data}, {24'd0, e});
            if (exp_q.size() == 0) busy_nx = 1'b0;
          end
        end
        if (exp_pulse && busy_m) overrun_m = 1'b1;
        if (exp_pulse && !busy_m) begin
          push_frame();
          busy_nx = 1'b1;
        end
        if (busy_m && !busy_nx) begin
          if (all_ready) chk("frame_len", len, FRAME_LEN);
          len = 0;
          all_ready = 1;
        end
        busy_m = busy_nx;
      end
    end
  end

  // driver tasks: inputs change 1 time unit after the rising edge
  task automatic cycles(input int n);
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic run_random_ready(input int n, input int num, input int den);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      tx_ready = ($urandom_range(0, den - 1) < num);
    end
  endtask

  task automatic wait_busy(input logic level, input int budget, input string name);
    int t = 0;
    while (busy !== level && t < budget) begin
      @(posedge clk); #1;
      t++;
    end
    chk(name, {31'd0, busy}, {31'd0, level});
  endtask

  task automatic drain(input string name);
    int t = 0;
    enable = 1'b0;
    tx_ready = 1'b1;
    while ((busy_m || busy) && t < 3000) begin
      @(posedge clk); #1;
      t++;
    end
    chk(name, exp_q.size(), 0);
  endtask

  initial begin
    cycles(3);
    reset = 1'b0;
    // fixed pattern, ready tied high, period 10
    mem_mode = 0; period = 32'd10; tx_ready = 1'b1; enable = 1'b1;
    cycles(700);
    // long stall in the middle of a word with random words
    mem_mode = 1;
    wait_busy(1'b0, 400, "wait_idle_stall");
    wait_busy(1'b1, 50, "wait_busy_stall");
    cycles(20);
    tx_ready = 1'b0;
    cycles(50);
    tx_ready = 1'b1;
    cycles(400);
    // period 100 with a 25% ready duty cycle: forces overruns
    period = 32'd100;
    run_random_ready(1500, 1, 4);
    // degenerate periods
    period = 32'd0;
    run_random_ready(300, 1, 2);
    period = 32'd1;
    run_random_ready(300, 1, 2);
    drain("drain_1");
    // reset in the middle of SEND, then frame counter restarts
    period = 32'd10; enable = 1'b1;
    wait_busy(1'b1, 50, "wait_busy_rst");
    cycles(8);
    reset = 1'b1;
    cycles(1);
    reset = 1'b0;
    cycles(400);
    drain("drain_2");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
